proc_seq_ctrl: RTL

PROC_SEQ_CTRL -- requirements
Module: proc_seq_ctrl

---
 rtl/proc_seq_pkg.sv | 146 ++++++++++++++
 rtl/proc_seq_wait_cnt.sv | 30 +++
 rtl/proc_seq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/proc_seq_pkg.sv
// rtl/proc_seq_pkg.sv - shared state codes, opcode/funct constants and control word table
package proc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXE    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_POP   = 6'h30;
  localparam logic [5:0] OP_PUSH  = 6'h38;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_AND  = 4'h1;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_ADD  = 4'h6;
  localparam logic [3:0] ALU_SUB  = 4'hA;
  localparam logic [3:0] ALU_SLT  = 4'hB;

  localparam logic [31:0] CW_PC_WRITE   = 32'h0000_0001;
  localparam logic [31:0] CW_PC_SRC0    = 32'h0000_0002;
  localparam logic [31:0] CW_PC_SRC1    = 32'h0000_0004;
  localparam logic [31:0] CW_WB_STAGE   = 32'h0000_0008;
  localparam logic [31:0] CW_IR_WRITE   = 32'h0000_0010;
  localparam logic [31:0] CW_RF_READ    = 32'h0000_0020;
  localparam logic [31:0] CW_REG_WRITE  = 32'h0000_0080;
  localparam logic [31:0] CW_ALU_EN     = 32'h0000_0100;
  localparam logic [31:0] CW_ALU_IMM    = 32'h0000_0200;
  localparam logic [31:0] CW_SP_ADJ     = 32'h0000_0400;
  localparam logic [31:0] CW_MEM_RD     = 32'h0001_0000;
  localparam logic [31:0] CW_MEM_WR     = 32'h0002_0000;
  localparam logic [31:0] CW_MEM_TO_REG = 32'h0080_0000;
  localparam logic [31:0] CW_WB_ALU     = 32'h0200_0000;
  localparam logic [31:0] CW_WB_MEM     = 32'h0600_0000;
  localparam logic [31:0] CW_RF_PORT    = 32'h1000_0000;

  function automatic logic [31:0] alu_cw(input logic [3:0] code);
    return {16'h0000, code, 12'h000};
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_POP);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_PUSH);
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    logic [3:0] code;
    case (fn)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      default: code = ALU_NONE;
    endcase
    return code;
  endfunction

  // ALU_NONE doubles as the "unknown opcode/funct" marker for every opcode but J.
  function automatic logic [3:0] op_alu(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] code;
    case (op)
      OP_RTYPE:                                 code = rtype_alu(fn);
      OP_ADDI, OP_LW, OP_SW, OP_POP, OP_PUSH:   code = ALU_ADD;
      OP_ANDI:                                  code = ALU_AND;
      OP_ORI:                                   code = ALU_OR;
      OP_BEQ, OP_BNE:                           code = ALU_SUB;
      default:                                  code = ALU_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [31:0] ctrl_word(input state_t st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic zero);
    logic [31:0] cw;
    logic [3:0]  alu;
    logic        taken;
    cw    = 32'h0;
    alu   = op_alu(op, fn);
    taken = (op == OP_BEQ) ? zero : !zero;
    case (st)
      ST_FETCH:  cw = CW_IR_WRITE;
      ST_DECODE: cw = CW_RF_READ;
      ST_EXE: begin
        if (alu != ALU_NONE) begin
          cw = CW_ALU_EN | alu_cw(alu);
          if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_LW || op == OP_SW)
            cw = cw | CW_ALU_IMM;
          if (op == OP_POP || op == OP_PUSH)
            cw = cw | CW_SP_ADJ;
        end
      end
      ST_MEM: begin
        if (is_load(op))
          cw = CW_MEM_RD;
        else if (is_store(op))
          cw = CW_MEM_WR;
      end
      ST_WB: begin
        case (op)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: begin
            if (alu != ALU_NONE)
              cw = CW_RF_PORT | CW_WB_ALU | alu_cw(alu) | CW_REG_WRITE |
                   CW_WB_STAGE | CW_PC_SRC0 | CW_PC_WRITE;
          end
          OP_LW, OP_POP:
            cw = CW_RF_PORT | CW_WB_MEM | CW_MEM_TO_REG | CW_REG_WRITE |
                 CW_WB_STAGE | CW_PC_SRC0 | CW_PC_WRITE;
          OP_SW, OP_PUSH:
            cw = CW_WB_STAGE | CW_PC_SRC0 | CW_PC_WRITE;
          OP_BEQ, OP_BNE:
            cw = alu_cw(ALU_SUB) | CW_WB_STAGE | CW_PC_WRITE |
                 (taken ? CW_PC_SRC0 : CW_PC_SRC1);
          OP_J:
            cw = CW_WB_STAGE | CW_PC_SRC0 | CW_PC_SRC1 | CW_PC_WRITE;
          default:
            cw = 32'h0;
        endcase
      end
      default: cw = 32'h0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/proc_seq_wait_cnt.sv
// rtl/proc_seq_wait_cnt.sv - memory wait-cycle counter with timeout compare
module proc_seq_wait_cnt
  import proc_seq_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      cnt <= 8'd0;
    else if (clr)
      cnt <= 8'd0;
    else if (inc)
      cnt <= cnt + 8'd1;
  end

  // Fires on the wait cycle that would bring the count up to WAIT_MAX.
  assign expire = inc && (cnt >= LIMIT);

endmodule

// File: rtl/proc_seq_ctrl.sv
// rtl/proc_seq_ctrl.sv - multi-cycle instruction sequencer; PROC_SEQ_MEM_SKIP_EN lets non-memory ops bypass MEM
module proc_seq_ctrl
  import proc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION,
  input  logic                  ZERO,
  input  logic                  MEM_READY,
  input  logic                  STALL,
  output logic [2:0]            STATE,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE,
  output logic                  TIMEOUT
);

  state_t                state_q;
  state_t                nxt;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [5:0]            op;
  logic [5:0]            fn;
  logic                  mem_ld;
  logic                  mem_st;
  logic                  to_timeout;
  logic                  wc_clr;
  logic                  wc_inc;
  logic                  wc_expire;
  logic                  unused_ir_bits;

  assign op             = ir_q[DATA_WIDTH-1 -: 6];
  assign fn             = ir_q[5:0];
  assign unused_ir_bits = ^ir_q[DATA_WIDTH-7:6];
  assign mem_ld         = is_load(op);
  assign mem_st         = is_store(op);
  assign STATE          = state_q;

  // In FETCH a low READ marks the one recovery cycle after a timeout.
  assign wc_inc = !STALL && !MEM_READY &&
                  (((state_q == ST_FETCH) && READ) ||
                   ((state_q == ST_MEM) && (mem_ld || mem_st)));

  always_comb begin
    nxt        = state_q;
    to_timeout = 1'b0;
    case (state_q)
      ST_IDLE:   nxt = ST_FETCH;
      ST_FETCH: begin
        if (READ) begin
          if (MEM_READY)
            nxt = ST_DECODE;
          else if (wc_expire)
            to_timeout = 1'b1;
        end
      end
      ST_DECODE: nxt = ST_EXE;
      ST_EXE: begin
`ifdef PROC_SEQ_MEM_SKIP_EN
        nxt = (mem_ld || mem_st) ? ST_MEM : ST_WB;
`else
        nxt = ST_MEM;
`endif
      end
      ST_MEM: begin
        if (!(mem_ld || mem_st) || MEM_READY)
          nxt = ST_WB;
        else if (wc_expire) begin
          nxt        = ST_FETCH;
          to_timeout = 1'b1;
        end
      end
      ST_WB:     nxt = ST_FETCH;
      default:   nxt = ST_IDLE;
    endcase
  end

  assign wc_clr = !STALL &&
                  (to_timeout || (((nxt == ST_FETCH) || (nxt == ST_MEM)) && (nxt != state_q)));

  proc_seq_wait_cnt #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (wc_clr),
    .inc    (wc_inc),
    .expire (wc_expire)
  );

  // Outputs are computed for the state being entered, so ZERO is captured at the
  // edge that opens WB and the branch word stays stable for the whole WB cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      CTRL    <= '0;
      READ    <= 1'b0;
      WRITE   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else if (STALL) begin
      TIMEOUT <= 1'b0;
    end else begin
      state_q <= nxt;
      TIMEOUT <= to_timeout;
      if ((state_q == ST_FETCH) && (nxt == ST_DECODE))
        ir_q <= INSTRUCTION;
      if (to_timeout) begin
        CTRL  <= '0;
        READ  <= 1'b0;
        WRITE <= 1'b0;
      end else begin
        CTRL  <= CTRL_WIDTH'(ctrl_word(nxt, op, fn, ZERO));
        READ  <= (nxt == ST_FETCH) || ((nxt == ST_MEM) && mem_ld);
        WRITE <= (nxt == ST_MEM) && mem_st;
      end
    end
  end

endmodule
